// File: rtl/instr_encoder.sv
// Packs symbolic RV32I requests into machine words and streams them into IMEM; MUL op gated by INSTR_ENCODER_MUL_EN.
// One-cycle latency from accept to IMEM write/err; in_ready only in RUN, dropped on start, after in_last or at the top address.
module instr_encoder #(
  parameter int IMEM_ADDR_W = 9,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [20:0]            in_imm,
  input  logic                   in_last,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   done,
  output logic                   full
);

  localparam logic [IMEM_ADDR_W-1:0] BASE = BASE_ADDR[IMEM_ADDR_W-1:0];

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FULL
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IMEM_ADDR_W-1:0] wr_ptr;
  logic [31:0]            enc_word;
  logic [1:0]             enc_code;
  logic                   accept;
  logic                   enc_ok;
  logic                   at_top;
  logic                   i_ok;
  logic                   b_ok;
  logic                   j_ok;

  // Sign-extension check: all bits above the field width must match its sign bit.
  assign i_ok = (&in_imm[20:11]) | ~(|in_imm[20:11]);
  assign b_ok = ((&in_imm[20:12]) | ~(|in_imm[20:12])) & ~in_imm[0];
  assign j_ok = ~in_imm[0];

  always_comb begin
    enc_word = '0;
    enc_code = 2'd0;
    case (in_op)
      3'd0: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      3'd1: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      3'd2: begin
        if (i_ok) enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_I};
        else      enc_code = 2'd2;
      end
      3'd3: begin
        if (b_ok) enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                              in_imm[4:1], in_imm[11], OP_B};
        else      enc_code = 2'd2;
      end
      3'd4: begin
        if (j_ok) enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, OP_J};
        else      enc_code = 2'd2;
      end
      3'd5: begin
        if (i_ok) enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
        else      enc_code = 2'd2;
      end
      3'd6: begin
        if (i_ok) enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STOR};
        else      enc_code = 2'd2;
      end
      default: begin
`ifdef INSTR_ENCODER_MUL_EN
        enc_word = {7'b0000001, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
`else
        enc_code = 2'd1;
`endif
      end
    endcase
  end

  assign in_ready = (state == S_RUN) & ~start;
  assign accept   = in_valid & in_ready;
  assign enc_ok   = (enc_code == 2'd0);
  assign at_top   = (wr_ptr == {IMEM_ADDR_W{1'b1}});
  assign done     = (state == S_DONE);
  assign full     = (state == S_FULL);

  // A write into the top word wins over in_last: IMEM exhaustion must stay visible.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (accept) begin
          if (enc_ok && at_top) state_nxt = S_FULL;
          else if (in_last)     state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = state;
    endcase
    if (start) state_nxt = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= BASE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state   <= state_nxt;
      imem_we <= accept & enc_ok;
      err     <= accept & ~enc_ok;
      if (start) begin
        wr_ptr <= BASE;
      end else if (accept && enc_ok) begin
        imem_addr  <= wr_ptr;
        imem_wdata <= enc_word;
        if (!at_top) wr_ptr <= wr_ptr + 1'b1;
      end
      if (accept && !enc_ok) err_code <= enc_code;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program loads plus a randomized stream against a cycle-level reference model.
module tb_instr_encoder;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [20:0]   in_imm;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          err;
  logic [1:0]    err_code;
  logic          done;
  logic          full;

  instr_encoder #(.IMEM_ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .err(err), .err_code(err_code),
    .done(done), .full(full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: is the loader accepting, is IMEM exhausted, next free word.
  bit          m_run, m_full, m_acc;
  int          m_ptr;
  bit          e_we, e_err, e_done;
  logic [AW-1:0] e_addr;
  logic [31:0] e_data;
  logic [1:0]  e_code;

  logic [31:0] img [DEPTH];
  int          n_wr;
  int          bnd [14] = '{-4097, -4096, -4095, -2049, -2048, -1, 2047, 2048,
                            4094, 4095, 4096, -1048576, 1048575, 1048574};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {err_code, word}; err_code 0 means the request is legal.
  function automatic logic [33:0] ref_enc(input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [20:0] imm21);
    int          imm;
    logic [31:0] u;
    logic [31:0] w;
    logic [1:0]  c;
    imm = int'($signed(imm21));
    u   = imm;
    w   = 32'd0;
    c   = 2'd0;
    case (op)
      3'd0: w = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
      3'd1: w = (32'h20 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
      3'd2: if (imm < -2048 || imm > 2047) c = 2'd2;
            else w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
      3'd3: if (imm < -4096 || imm > 4094 || (imm % 2) != 0) c = 2'd2;
            else w = {u[12], u[10:5], rs2, rs1, 3'b000, u[4:1], u[11], 7'b1100011};
      3'd4: if ((imm % 2) != 0) c = 2'd2;
            else w = {u[20], u[10:1], u[11], u[19:12], rd, 7'b1101111};
      3'd5: if (imm < -2048 || imm > 2047) c = 2'd2;
            else w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'h2 << 12) | (32'(rd) << 7) | 32'h03;
      3'd6: if (imm < -2048 || imm > 2047) c = 2'd2;
            else w = {u[11:5], rs2, rs1, 3'b010, u[4:0], 7'b0100011};
      default: begin
`ifdef INSTR_ENCODER_MUL_EN
        w = (32'h1 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
`else
        c = 2'd1;
`endif
      end
    endcase
    return {c, w};
  endfunction

  task automatic model_edge();
    logic [33:0] r;
    if (!arst_n) begin
      m_run = 0; m_full = 0; m_acc = 0; m_ptr = BASE;
      e_we = 0; e_err = 0; e_done = 0;
      e_addr = AW'(BASE); e_data = 32'd0; e_code = 2'd0;
    end else begin
      m_acc  = m_run && !start && in_valid;
      e_we   = 0; e_err = 0; e_done = 0;
      if (start) begin
        m_run = 1; m_full = 0; m_ptr = BASE;
      end else if (m_acc) begin
        r = ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm);
        if (r[33:32] == 2'd0) begin
          e_we = 1; e_addr = m_ptr[AW-1:0]; e_data = r[31:0];
          if (m_ptr == DEPTH - 1) begin m_full = 1; m_run = 0; end
          else m_ptr++;
        end else begin
          e_err = 1; e_code = r[33:32];
        end
        if (in_last && !m_full) begin m_run = 0; e_done = 1; end
      end
    end
  endtask

  task automatic check_outputs();
    check("imem_we", 32'(imem_we), 32'(e_we));
    check("imem_addr", 32'(imem_addr), 32'(e_addr));
    check("imem_wdata", imem_wdata, e_data);
    check("err", 32'(err), 32'(e_err));
    check("err_code", 32'(err_code), 32'(e_code));
    check("done", 32'(done), 32'(e_done));
    check("full", 32'(full), 32'(m_full));
    if (imem_we === 1'b1) begin
      img[imem_addr] = imem_wdata;
      n_wr++;
    end
  endtask

  task automatic step();
    #1;
    check("in_ready", 32'(in_ready), 32'(m_run && !start));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_req(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input int imm, input logic last);
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm[20:0];
    in_last = last;
  endtask

  task automatic rand_req();
    int imm;
    case ($urandom_range(0, 2))
      0:       imm = int'($urandom_range(0, 64)) - 32;
      1:       imm = bnd[$urandom_range(0, 13)];
      default: imm = int'($urandom);
    endcase
    set_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), imm,
            $urandom_range(0, 19) == 0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) img[i] = 32'd0;
    n_wr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 21'd0;
    clear_img();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    step();
    arst_n = 1'b1;

    // Program: ADD x3,x1,x2 ; ADDI x1,x0,5 ; LW x5,8(x2) (last)
    start = 1'b1; step(); start = 1'b0;
    set_req(3'd0, 5'd3, 5'd1, 5'd2, 0, 1'b0); step();
    set_req(3'd2, 5'd1, 5'd0, 5'd0, 5, 1'b0); step();
    set_req(3'd5, 5'd5, 5'd2, 5'd0, 8, 1'b1); step();
    check("done_with_lw", 32'(done), 32'd1);
    in_valid = 1'b0; in_last = 1'b0; step(); step();
    check("img_add", img[0], 32'h002081B3);
    check("img_addi", img[1], 32'h00500093);
    check("img_lw", img[2], 32'h00812283);

    // SUB, BEQ, two rejected immediates, ADD at unchanged address, op 7
    clear_img();
    start = 1'b1; step(); start = 1'b0;
    set_req(3'd1, 5'd3, 5'd1, 5'd2, 0, 1'b0); step();
    set_req(3'd3, 5'd0, 5'd1, 5'd2, 8, 1'b0); step();
    set_req(3'd2, 5'd1, 5'd0, 5'd0, 2048, 1'b0); step();
    check("addi_range_err", {29'd0, err, err_code}, 32'h6);
    set_req(3'd3, 5'd0, 5'd1, 5'd2, 7, 1'b0); step();
    check("beq_odd_err", {29'd0, err, err_code}, 32'h6);
    set_req(3'd0, 5'd4, 5'd5, 5'd6, 0, 1'b0); step();
    check("addr_after_err", 32'(imem_addr), 32'd2);
    set_req(3'd7, 5'd3, 5'd1, 5'd2, 0, 1'b0); step();
`ifdef INSTR_ENCODER_MUL_EN
    check("img_mul", img[3], 32'h022081B3);
`else
    check("mul_illegal", {29'd0, imem_we, err_code}, 32'h1);
`endif
    set_req(3'd0, 5'd3, 5'd1, 5'd2, 0, 1'b1); step();
    in_valid = 1'b0; in_last = 1'b0; step(); step();
    check("img_sub", img[0], 32'h402081B3);
    check("img_beq", img[1], 32'h00208463);
    check("img_add2", img[2], 32'h00628233);

    // Fill IMEM with valid held high, then restart
    clear_img();
    start = 1'b1; step(); start = 1'b0;
    set_req(3'd0, 5'd1, 5'd1, 5'd1, 0, 1'b0);
    for (int i = 0; i < DEPTH + 4; i++) step();
    check("full_writes", 32'(n_wr), 32'(DEPTH));
    check("full_level", 32'(full), 32'd1);
    in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
    set_req(3'd0, 5'd2, 5'd2, 5'd2, 0, 1'b0); step();
    check("restart_addr", {31'd0, imem_we} | (32'(imem_addr) << 1), 32'(BASE << 1) | 32'd1);

    // Reset in the middle of a stream
    step();
    arst_n = 1'b0; step();
    arst_n = 1'b1; step();
    check("no_write_after_rst", 32'(imem_we), 32'd0);
    in_valid = 1'b0;

    // Randomized stream
    for (int i = 0; i < 3000; i++) begin
      arst_n = ($urandom_range(0, 199) != 0);
      start  = ($urandom_range(0, m_run ? 39 : 5) == 0);
      if (!(in_valid && !m_acc)) begin
        if ($urandom_range(0, 3) != 0) rand_req();
        else in_valid = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
